// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter: FIFO of parallel words, framed LSB-first as
// start, DATA_W data bits, optional parity, STOP_BITS stop bits; line idles high.
module serial_tx_fifo #(
    parameter int DATA_W       = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_n,
    output logic              data_out,
    output logic              charSent,
    output logic              busy,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overrun
);
    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic              head_par;

    logic [2:0]        state;
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par;
    logic              bit_end, last_stop;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = !load_n && !fifo_full;
    assign head       = mem[rd_ptr];
    assign head_par   = (^head) ^ 1'(PARITY_ODD);

    assign bit_end   = enable && (tick == TICK_LAST);
    assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
    // A new word is taken either from idle or straight out of the last stop bit.
    assign pop       = !fifo_empty && enable && ((state == S_IDLE) || last_stop);
    assign charSent  = last_stop && !reset;
    assign busy      = (state != S_IDLE);
    assign shift_nxt = shift >> 1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (!load_n && fifo_full) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            data_out <= 1'b1;
        end else begin
            if (state != S_IDLE && enable)
                tick <= bit_end ? '0 : tick + TICK_W'(1);
            case (state)
                S_IDLE: if (pop) begin
                    shift    <= head;
                    par      <= head_par;
                    data_out <= 1'b0;
                    tick     <= '0;
                    state    <= S_START;
                end
                S_START: if (bit_end) begin
                    state    <= S_DATA;
                    bit_cnt  <= '0;
                    data_out <= shift[0];
                end
                S_DATA: if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY_EN != 0) begin
                            state    <= S_PARITY;
                            data_out <= par;
                        end else begin
                            state    <= S_STOP;
                            data_out <= 1'b1;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        shift    <= shift_nxt;
                        data_out <= shift_nxt[0];
                    end
                end
                S_PARITY: if (bit_end) begin
                    state    <= S_STOP;
                    bit_cnt  <= '0;
                    data_out <= 1'b1;
                end
                S_STOP: if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift    <= head;
                            par      <= head_par;
                            data_out <= 1'b0;
                            state    <= S_START;
                        end else begin
                            data_out <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    data_out <= 1'b1;
                end
            endcase
        end
    end
endmodule
